// File: rtl/oka_seq_mul12.sv
// 12x12 carry-less multiplier: even/odd Karatsuba split, one 6-bit OKA core
// shared across three cycles, recombined into a 23-bit product.
module oka_6bit (
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic [10:0] p
);
  function automatic logic [4:0] clmul3(input logic [2:0] x, input logic [2:0] z);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      if (z[i]) r = r ^ ({2'b00, x} << i);
    end
    return r;
  endfunction

  logic [4:0] p_lo, p_hi, p_mid;

  // One Karatsuba level on 3-bit halves.
  assign p_lo  = clmul3(a[2:0], b[2:0]);
  assign p_hi  = clmul3(a[5:3], b[5:3]);
  assign p_mid = clmul3(a[2:0] ^ a[5:3], b[2:0] ^ b[5:3]);
  assign p = {6'b0, p_lo} ^ ({6'b0, p_mid ^ p_lo ^ p_hi} << 3) ^ ({6'b0, p_hi} << 6);
endmodule

module oka_seq_mul12 #(
  parameter int N     = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   y,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;
  localparam int YW = 2 * N - 1;

  typedef enum logic [2:0] {IDLE, EE, OO, MID, DONE} state_t;

  state_t           state_q, state_d;
  logic [H-1:0]     ae_q, ao_q, be_q, bo_q;
  logic [H-1:0]     ae_d, ao_d, be_d, bo_d;
  logic [H-1:0]     ae_in, ao_in, be_in, bo_in;
  logic [PW-1:0]    p_ee_q, p_oo_q, p_ee_d, p_oo_d;
  logic [YW-1:0]    y_q, y_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [H-1:0]     core_a, core_b;
  logic [PW-1:0]    core_p;

  function automatic logic [YW-1:0] spread(input logic [PW-1:0] p);
    logic [YW-1:0] r;
    r = '0;
    for (int i = 0; i < PW; i++) r[2*i] = p[i];
    return r;
  endfunction

  always_comb begin
    ae_in = '0;
    ao_in = '0;
    be_in = '0;
    bo_in = '0;
    for (int j = 0; j < H; j++) begin
      ae_in[j] = a[2*j];
      ao_in[j] = a[2*j+1];
      be_in[j] = b[2*j];
      bo_in[j] = b[2*j+1];
    end
  end

  // Core operands come from registered state only, keeping the core path reg-to-reg.
  always_comb begin
    core_a = '0;
    core_b = '0;
    case (state_q)
      EE:      begin core_a = ae_q;        core_b = be_q;        end
      OO:      begin core_a = ao_q;        core_b = bo_q;        end
      MID:     begin core_a = ae_q ^ ao_q; core_b = be_q ^ bo_q; end
      default: begin core_a = '0;          core_b = '0;          end
    endcase
  end

  oka_6bit u_core (.a(core_a), .b(core_b), .p(core_p));

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign op_count  = op_count_q;

  always_comb begin
    state_d     = state_q;
    ae_d        = ae_q;
    ao_d        = ao_q;
    be_d        = be_q;
    bo_d        = bo_q;
    p_ee_d      = p_ee_q;
    p_oo_d      = p_oo_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ae_d = ae_in; ao_d = ao_in; be_d = be_in; bo_d = bo_in;
            state_d = EE;
          end
        end
        EE: begin
          p_ee_d  = core_p;
          state_d = OO;
        end
        OO: begin
          p_oo_d  = core_p;
          state_d = MID;
        end
        MID: begin
          y_d = spread(p_ee_q) ^ (spread(p_ee_q ^ p_oo_q ^ core_p) << 1)
              ^ (spread(p_oo_q) << 2);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (op_count_q != {CNT_W{1'b1}}) op_count_d = op_count_q + CNT_W'(1);
            if (in_valid) begin
              ae_d = ae_in; ao_d = ao_in; be_d = be_in; bo_d = bo_in;
              state_d = EE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ae_q        <= '0;
      ao_q        <= '0;
      be_q        <= '0;
      bo_q        <= '0;
      p_ee_q      <= '0;
      p_oo_q      <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ae_q        <= ae_d;
      ao_q        <= ao_d;
      be_q        <= be_d;
      bo_q        <= bo_d;
      p_ee_q      <= p_ee_d;
      p_oo_q      <= p_oo_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end
endmodule

// File: tb/tb_oka_seq_mul12.sv
// Bench for oka_seq_mul12: transaction-level model checked every cycle,
// plus directed vectors with hand-computed products.
module tb_oka_seq_mul12;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] a = '0;
  logic [11:0] b = '0;
  logic        in_ready, out_valid, busy;
  logic [22:0] y;
  logic [15:0] op_count;
  logic        in_ready_s, out_valid_s, busy_s;
  logic [22:0] y_s;
  logic [3:0]  op_count_s;

  int checks = 0;
  int errors = 0;

  logic [22:0] exp_q[$];
  int          m_cd = 0;
  bit          m_valid = 1'b0;
  logic [22:0] m_y = '0;
  int unsigned m_cnt = 0;

  oka_seq_mul12 dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .busy(busy), .op_count(op_count)
  );

  oka_seq_mul12 #(.N(12), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s),
    .busy(busy_s), .op_count(op_count_s)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] ref_mul(input logic [11:0] x, input logic [11:0] z);
    logic [22:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      if (z[i]) r = r ^ ({11'b0, x} << i);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the transaction model, then advance the model.
  always @(negedge clk) begin : monitor
    bit m_busy, exp_ir, xfer, acc;
    int unsigned cnt_s;
    if (!rst_n) begin
      m_cd = 0; m_valid = 1'b0; m_y = '0; m_cnt = 0;
      exp_q.delete();
    end
    m_busy = (m_cd > 0) || m_valid;
    exp_ir = !m_busy || (m_valid && out_ready);
    cnt_s  = (m_cnt > 15) ? 15 : m_cnt;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("y", 32'(y), 32'(m_y));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    chk("out_valid_s", 32'(out_valid_s), 32'(m_valid));
    chk("in_ready_s", 32'(in_ready_s), 32'(exp_ir));
    chk("busy_s", 32'(busy_s), 32'(m_busy));
    chk("y_s", 32'(y_s), 32'(m_y));
    chk("op_count_s", 32'(op_count_s), cnt_s);
    if (rst_n) begin
      if (flush) begin
        m_valid = 1'b0;
        m_cd = 0;
        exp_q.delete();
      end else begin
        xfer = m_valid && out_ready;
        acc  = in_valid && exp_ir;
        if (xfer) begin
          m_valid = 1'b0;
          if (m_cnt < 65535) m_cnt++;
        end
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0 && exp_q.size() > 0) begin
            m_y = exp_q.pop_front();
            m_valid = 1'b1;
          end
        end
        if (acc) begin
          exp_q.push_back(ref_mul(a, b));
          m_cd = 3;
        end
      end
    end
  end

  // Holds in_valid until the block takes the operands; returns 1ns after the accept edge.
  task automatic wait_accept(output bit ok);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    ok = acc;
    if (!acc) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_op(input logic [11:0] ta, input logic [11:0] tb,
                       input logic [22:0] lit, input bit use_lit);
    bit ok, got;
    int lat;
    a = ta; b = tb; out_ready = 1'b1; in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    if (!ok) return;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      got = out_valid;
    end
    chk("latency", 32'(lat), 32'(3));
    if (use_lit) begin
      chk("model_pin", 32'(ref_mul(ta, tb)), 32'(lit));
      chk("y_lit", 32'(y), 32'(lit));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit ok;
    logic [22:0] ys;
    logic [15:0] cnt0;
    int n;
    logic [11:0] va[4];
    logic [11:0] vb[4];
    va[0] = 12'h123; vb[0] = 12'h456;
    va[1] = 12'hABC; vb[1] = 12'h0F0;
    va[2] = 12'hFFF; vb[2] = 12'hFFF;
    va[3] = 12'h801; vb[3] = 12'h003;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_y", 32'(y), 32'(0));
    rst_n = 1'b1;

    do_op(12'h003, 12'h003, 23'h000005, 1'b1);
    chk("count_first", 32'(op_count), 32'(1));
    do_op(12'h800, 12'h800, 23'h400000, 1'b1);
    do_op(12'hFFF, 12'h001, 23'h000FFF, 1'b1);
    do_op(12'h007, 12'h007, 23'h000015, 1'b1);

    // Backpressure: result parks in DONE.
    out_ready = 1'b0;
    a = 12'h0A5; b = 12'h03C; in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    ys = y;
    cnt0 = op_count;
    chk("bp_y_model", 32'(ys), 32'(ref_mul(12'h0A5, 12'h03C)));
    repeat (5) begin
      @(negedge clk);
      chk("bp_y_hold", 32'(y), 32'(ys));
      chk("bp_valid_hold", 32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_count", 32'(op_count), 32'(cnt0) + 32'(1));
    chk("bp_valid_clear", 32'(out_valid), 32'(0));

    // Back-to-back with in_valid held.
    cnt0 = op_count;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i];
      wait_accept(ok);
    end
    in_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    chk("b2b_count", 32'(op_count), 32'(cnt0) + 32'(4));

    // Flush while the core works on the odd sub-product.
    cnt0 = op_count;
    a = 12'h5A5; b = 12'h3C3; in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", 32'(busy), 32'(0));
    chk("flush_valid", 32'(out_valid), 32'(0));
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_valid", 32'(out_valid), 32'(0));
    end
    chk("flush_count", 32'(op_count), 32'(cnt0));

    // Flush in IDLE swallows a simultaneous in_valid.
    @(posedge clk);
    #1 flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'(0));

    // Asynchronous reset in MID.
    a = 12'hFFF; b = 12'hFFF; in_valid = 1'b1;
    wait_accept(ok);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'(0));
    chk("arst_valid", 32'(out_valid), 32'(0));
    chk("arst_count", 32'(op_count), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      do_op(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), '0, 1'b0);
    end
    chk("rand_count", 32'(op_count), 32'(10000));
    chk("sat_count", 32'(op_count_s), 32'(15));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
